// File: rtl/cpu_pipe_pkg.sv
// Purpose : shared constants, stage bundle types and skid-buffer state encoding for the CPU pipeline.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package cpu_pipe_pkg;

   localparam int unsigned PC_W  = 32;
   localparam int unsigned INS_W = 32;

   // All-zero instruction word decodes as a NOP in this pipeline.
   localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [INS_W-1:0] ins;
   } if_id_t;

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [INS_W-1:0] ins;
      logic [31:0]      rs1_val;
      logic [31:0]      rs2_val;
   } id_ex_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     alu_res;
      logic [4:0]      rd;
   } ex_mem_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     wb_val;
      logic [4:0]      rd;
   } mem_wb_t;

   // Occupancy of the two-entry skid buffer; 2'b11 is unused and recovers to EMPTY.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } skid_state_t;

endpackage

// File: rtl/pipe_stage_buf_fsm.sv
// Purpose : occupancy control for the two-entry skid stage; produces in_ready, out_valid and register enables.
// Latency : in_ready and out_valid are decoded from the state register only (no combinational input path).
// Backpressure: in_ready drops when both entries are full; main refills from skid on the next downstream consume.
// Ports   : clk, rst (async active-low), flush, in_valid, out_ready -> in_ready, out_valid,
//           main_load / main_sel_skid (main register enable and source), skid_load (skid register enable).
module pipe_stage_buf_fsm
   import cpu_pipe_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic out_valid,
   output logic main_load,
   output logic main_sel_skid,
   output logic skid_load
);

   skid_state_t state_q;
   skid_state_t state_d;

   // Decoded so that the unused encoding neither accepts nor presents data.
   assign in_ready  = (state_q == EMPTY) || (state_q == ONE);
   assign out_valid = (state_q == ONE)   || (state_q == TWO);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (in_valid) state_d = ONE;
            ONE: begin
               if (in_valid && !out_ready) begin
                  state_d = TWO;
               end else if (!in_valid && out_ready) begin
                  state_d = EMPTY;
               end
            end
            TWO:     if (out_ready) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      main_load     = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      if (!flush) begin
         case (state_q)
            EMPTY: main_load = in_valid;
            ONE: begin
               // Consumed and refilled together: new data goes straight to main.
               main_load = in_valid && out_ready;
               skid_load = in_valid && !out_ready;
            end
            TWO: begin
               // Skid holds the younger entry; promote it when main is consumed.
               main_load     = out_ready;
               main_sel_skid = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Purpose : pipeline stage register with valid/ready handshake, flush and optional two-entry skid buffer.
// Latency : one cycle in->out when not stalled; one entry per cycle throughput in both modes.
// Backpressure: SKID=1 registered in_ready (low only when two entries held); SKID=0 in_ready = out_ready || !out_valid.
// Ports   : clk, rst (async active-low), flush, in_valid/in_ready/in_data (upstream),
//           out_valid/out_ready/out_data (downstream; out_data always from the main register).
module pipe_stage_buf
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 64,
   parameter bit               SKID      = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] main_q;

   assign out_data = main_q;

   if (SKID) begin : g_skid
      logic             main_load;
      logic             main_sel_skid;
      logic             skid_load;
      logic [WIDTH-1:0] skid_q;

      pipe_stage_buf_fsm u_fsm (
         .clk           (clk),
         .rst           (rst),
         .flush         (flush),
         .in_valid      (in_valid),
         .out_ready     (out_ready),
         .in_ready      (in_ready),
         .out_valid     (out_valid),
         .main_load     (main_load),
         .main_sel_skid (main_sel_skid),
         .skid_load     (skid_load)
      );

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
         end else if (flush) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
         end else begin
            if (main_load) main_q <= main_sel_skid ? skid_q : in_data;
            if (skid_load) skid_q <= in_data;
         end
      end
   end else begin : g_single
      logic valid_q;

      // Through-path: a consume this cycle frees the single entry for refill.
      assign in_ready  = out_ready || !valid_q;
      assign out_valid = valid_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            valid_q <= 1'b0;
            main_q  <= RESET_VAL;
         end else if (flush) begin
            valid_q <= 1'b0;
            main_q  <= RESET_VAL;
         end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            main_q  <= in_data;
         end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule
